// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS datapath: MULT/DIV unit state
// encoding and operand sizing.
package mips_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mult_div_state_t;

endpackage : mips_pkg

// File: rtl/restoring_div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift in the next
// dividend bit, trial-subtract the divisor, keep the difference when it fits.
module restoring_div_step
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividend_bit,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_in < divisor always holds, so a clear top bit of diff means shifted >= divisor
  // and the kept difference fits back into WIDTH bits.
  assign shifted = {rem_in, dividend_bit};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule : restoring_div_step

// File: rtl/mult_div_unit.sv
// Sequential signed MULT/DIV unit: radix-2 Booth multiply and restoring divide,
// one iteration per clock, fixed latency, results held in hi/lo.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mult_op,
  input  logic             div_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  mult_div_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH:0]   m_q, m_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             bzero_q, bzero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH-1:0] div_rem;
  logic             div_qbit;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  assign abs_a = op_a[WIDTH-1] ? -op_a : op_a;
  assign abs_b = op_b[WIDTH-1] ? -op_b : op_b;

  // Booth recoding of {Q[0], q-1}: 01 adds the multiplicand, 10 subtracts it.
  always_comb begin
    booth_sum = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_q;
      2'b10:   booth_sum = acc_q - m_q;
      default: booth_sum = acc_q;
    endcase
  end

  // Divide reuses acc as the partial remainder and Q as dividend/quotient shifter.
  restoring_div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem_in      (acc_q[WIDTH-1:0]),
    .divisor     (m_q[WIDTH-1:0]),
    .dividend_bit(q_q[WIDTH-1]),
    .rem_out     (div_rem),
    .q_bit       (div_qbit)
  );

  // Truncating division: quotient sign from the operand signs, remainder from the dividend.
  assign quot_fix = (sign_a_q ^ sign_b_q) ? -q_q : q_q;
  assign rem_fix  = sign_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    acc_d      = acc_q;
    q_d        = q_q;
    qm1_d      = qm1_q;
    m_d        = m_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    bzero_d    = bzero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE: begin
        if (mult_op || div_op) begin
          cnt_d      = CNT_W'(WIDTH - 1);
          last_d     = 1'b0;
          div_zero_d = 1'b0;
          sign_a_d   = op_a[WIDTH-1];
          sign_b_d   = op_b[WIDTH-1];
          bzero_d    = (op_b == '0);
          acc_d      = '0;
          qm1_d      = 1'b0;
          if (mult_op) begin
            state_d = MULT;
            q_d     = op_b;
            m_d     = {op_a[WIDTH-1], op_a};
          end else begin
            state_d = DIV;
            q_d     = abs_a;
            m_d     = {1'b0, abs_b};
          end
        end
      end

      MULT, DIV: begin
        if (last_q) begin
          // All WIDTH iterations are in; this edge applies the fixup and writes hi/lo.
          state_d = DONE;
          if (state_q == MULT) begin
            hi_d = acc_q[WIDTH-1:0];
            lo_d = q_q;
          end else if (bzero_q) begin
            div_zero_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end else begin
          if (state_q == MULT) begin
            acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
            qm1_d = q_q[0];
          end else begin
            acc_d = {1'b0, div_rem};
            q_d   = {q_q[WIDTH-2:0], div_qbit};
          end
          if (cnt_q == '0) begin
            last_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      acc_q      <= '0;
      q_q        <= '0;
      qm1_q      <= 1'b0;
      m_q        <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      bzero_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      acc_q      <= acc_d;
      q_q        <= q_d;
      qm1_q      <= qm1_d;
      m_q        <= m_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      bzero_q    <= bzero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q == MULT) || (state_q == DIV);
  assign done     = (state_q == DONE);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule : mult_div_unit

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a vector table of signed MULT/DIV cases plus
// hand-written sequences for reset abort and start-while-busy.
module tb_mult_div_unit;

  logic        clock;
  logic        reset;
  logic        mult_op;
  logic        div_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        m;
    logic        d;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vq[$];

  mult_div_unit dut (
    .clock   (clock),
    .reset   (reset),
    .mult_op (mult_op),
    .div_op  (div_op),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .div_zero(div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    vec_t v;
    v.name = name; v.m = m; v.d = d; v.a = a; v.b = b;
    v.hi = ehi; v.lo = elo; v.dz = edz;
    vq.push_back(v);
  endtask

  // Presents a start for one cycle; returns at the negedge after the start edge.
  task automatic launch(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    mult_op = m; div_op = d; op_a = a; op_b = b;
    @(posedge clock);
    @(negedge clock);
    mult_op = 1'b0; div_op = 1'b0;
    op_a = $urandom; op_b = $urandom;
  endtask

  // Counts edges (start edge = 1) until done is seen at a negedge, bounded.
  task automatic wait_done(input int start, output int lat);
    lat = start;
    while (!done && lat < 100) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
  endtask

  int lat;

  initial begin
    reset = 1'b1; mult_op = 1'b0; div_op = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    reset = 1'b0;

    add_vec("mul_7_x_m3",     1, 0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    add_vec("mul_max_x_max",  1, 0, 32'h7FFFFFFF,   32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 0);
    add_vec("mul_min_x_min",  1, 0, 32'h80000000,   32'h80000000, 32'h40000000, 32'h00000000, 0);
    add_vec("mul_m5_x_m6",    1, 0, 32'hFFFFFFFB,   32'hFFFFFFFA, 32'h00000000, 32'h0000001E, 0);
    add_vec("mul_0_x_k",      1, 0, 32'd0,          32'h12345678, 32'h00000000, 32'h00000000, 0);
    add_vec("div_m7_by_2",    0, 1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    add_vec("div_7_by_m2",    0, 1, 32'd7,          32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0);
    add_vec("div_100_by_7",   0, 1, 32'd100,        32'd7,        32'h00000002, 32'h0000000E, 0);
    add_vec("div_m100_by_m7", 0, 1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 0);
    add_vec("div_5_by_2",     0, 1, 32'd5,          32'd2,        32'h00000001, 32'h00000002, 0);
    add_vec("div_5_by_0",     0, 1, 32'd5,          32'd0,        32'h00000001, 32'h00000002, 1);
    add_vec("div_min_by_m1",  0, 1, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
    add_vec("both_ops_mult",  1, 1, 32'd6,          32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6, 0);

    for (int i = 0; i < vq.size(); i++) begin
      launch(vq[i].m, vq[i].d, vq[i].a, vq[i].b);
      chk({vq[i].name, "_busy"}, 32'(busy), 32'd1);
      wait_done(1, lat);
      $display("%s: a=%h b=%h hi=%h lo=%h dz=%b lat=%0d",
               vq[i].name, vq[i].a, vq[i].b, hi, lo, div_zero, lat);
      chk({vq[i].name, "_lat"}, 32'(lat), 32'd34);
      chk({vq[i].name, "_hi"}, hi, vq[i].hi);
      chk({vq[i].name, "_lo"}, lo, vq[i].lo);
      chk({vq[i].name, "_dz"}, 32'(div_zero), 32'(vq[i].dz));
      chk({vq[i].name, "_busy_done"}, 32'(busy), 32'd0);
      @(negedge clock);
      chk({vq[i].name, "_pulse"}, 32'(done), 32'd0);
    end

    // Reset in the middle of a multiply aborts it and clears everything.
    launch(1'b1, 1'b0, 32'd1234, 32'd5678);
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_dz", 32'(div_zero), 32'd0);
    $display("abort: busy=%b done=%b hi=%h lo=%h dz=%b", busy, done, hi, lo, div_zero);

    // Start presented together with reset release is taken on the very next edge.
    reset = 1'b0; mult_op = 1'b1; op_a = 32'd3; op_b = 32'd4;
    @(posedge clock);
    @(negedge clock);
    chk("post_rst_busy", 32'(busy), 32'd1);
    // Starts seen while busy must be ignored.
    op_a = 32'd100; op_b = 32'd100;
    repeat (3) @(negedge clock);
    chk("ignore_busy", 32'(busy), 32'd1);
    mult_op = 1'b0;
    div_op = 1'b1;
    @(negedge clock);
    div_op = 1'b0;
    wait_done(5, lat);
    $display("mul_3_x_4: hi=%h lo=%h dz=%b lat=%0d", hi, lo, div_zero, lat);
    chk("mul_3x4_lat", 32'(lat), 32'd34);
    chk("mul_3x4_hi", hi, 32'd0);
    chk("mul_3x4_lo", lo, 32'd12);
    @(negedge clock);
    @(negedge clock);
    chk("idle_after", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mult_div_unit
